oport_uart_tx: RTL and testbench
================================

Name: oport_uart_tx

Overview:
- Downstream consumer of the toy microprocessor's output port.
- Each byte the CPU writes to its O register is queued in a small FIFO and sent on a single serial line as an 8N1 UART frame.
- Decouples CPU instruction timing from the slow serial rate, so several OUT instructions can issue back-to-back without stalling the CPU.
- Integration: `data` ← OPORT; `wr_en` ← O-register load enable (CW[6]) registered by one clock, so that `data` already holds the new value when `wr_en` is sampled.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥2.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  8  byte to enqueue; sampled when wr_en=1.
- wr_en  input  1  enqueue request, one per byte per cycle.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high while a frame is in progress (state≠IDLE).
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (async, rst=1), applies immediately, including mid-frame:
  - tx=1, busy=0, empty=1, full=0, count=0, overflow=0.
  - FIFO pointers=0, state=IDLE, baud counter=0, bit index=0.
- FIFO: circular buffer with wr_ptr/rd_ptr wrapping modulo FIFO_DEPTH; count tracks occupancy.
- Write: accepted at the edge where wr_en=1 and full=0 (full as seen before that edge).
  - If full=1, the write is dropped and overflow sets at that edge, even if a pop occurs in the same cycle.
  - overflow clears only on rst.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- State machine, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If empty=0 at an edge: pop head into 8-bit shift reg, state→START, tx→0, baud counter→0.
  - START: tx=0 for CLKS_PER_BIT cycles, then state→DATA with tx=shift[0], bit index=0.
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. At the end of each bit, shift right and increment bit index. After bit 7 completes, state→STOP, tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle edge:
    - if empty=0, pop the next byte and go straight to START (no idle gap);
    - else state→IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Frame length: exactly 10×CLKS_PER_BIT cycles.
- Latency, from an empty FIFO in IDLE:
  - wr_en sampled at edge E0 → empty=0 after E0.
  - Pop at E1 → tx falls after E1 (2 edges after the write).
- Changes to `data` while wr_en=0 have no effect.
- A popped byte is immune to later FIFO writes.
- count never exceeds FIFO_DEPTH and never underflows. Pop occurs only when empty=0.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset idle: assert rst mid-run → tx=1, busy=0, empty=1, count=0, overflow=0, all immediately without a clock edge.
- Single byte: write 0xA5 → tx falls 2 edges later; line shows 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles, 40 cycles total; then busy=0, empty=1.
- Back-to-back: write 0x01, 0x80, 0xFF on consecutive cycles → count peaks at 2 (first byte popped at E1); three frames sent contiguously (120 cycles, no idle between STOP and START); bytes appear in order.
- Overflow: with transmitter busy, write 6 bytes on consecutive cycles → count reaches 4, full=1; remaining writes dropped; overflow=1 and stays 1; only the first 5 bytes are transmitted (1 in flight + 4 queued).
- Full with simultaneous pop: FIFO full, issue a write on the exact cycle STOP completes and pops → write rejected, overflow=1, count=3 after that edge.
- Reset mid-frame: rst asserted during DATA bit 3 of 0x3C → tx=1 at once; after release nothing is sent until a new write; new write of 0x55 transmits correctly.

Source files
------------

// File: rtl/oport_uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : oport_uart_tx_if
// Brief    : Byte-enqueue and serial-status bundle for the output-port UART.
// Revision : 1.0
// ============================================================================
interface oport_uart_tx_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int c_count_w = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]           data;
    logic                 wr_en;
    logic                 tx;
    logic                 busy;
    logic                 empty;
    logic                 full;
    logic [c_count_w-1:0] count;
    logic                 overflow;

    modport master (
        output data, wr_en,
        input  tx, busy, empty, full, count, overflow
    );

    modport slave (
        input  data, wr_en,
        output tx, busy, empty, full, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/oport_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : oport_uart_tx
// Brief    : Queues CPU output-port bytes in a small FIFO and sends them as
//            back-to-back 8N1 UART frames.
// Revision : 1.0
// ============================================================================
module oport_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input wire logic       clk,
    input wire logic       rst,
    oport_uart_tx_if.slave bus
);
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_count_w = c_ptr_w + 1;
    localparam int c_baud_w  = $clog2(CLKS_PER_BIT);

    localparam logic [c_count_w-1:0] c_depth     = c_count_w'(FIFO_DEPTH);
    localparam logic [c_baud_w-1:0]  c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_count_w-1:0] r_count;
    logic                 r_overflow;

    logic [1:0]           r_state;
    logic [c_baud_w-1:0]  r_baud;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.wr_en & ~w_full;
    assign w_bit_end = (r_baud == c_baud_last);
    // Pop from IDLE, or at the last STOP cycle so frames run with no idle gap
    assign w_pop     = ~w_empty & ((r_state == c_idle) ||
                                   ((r_state == c_stop) && w_bit_end));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            // A write seen while full is lost even if a pop frees a slot now
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_w'(1);
                2'b01:   r_count <= r_count - c_count_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                c_idle: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= c_start;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                    end
                end
                c_start: begin
                    if (w_bit_end) begin
                        r_state <= c_data;
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_baud  <= '0;
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                c_data: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= c_stop;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                c_stop: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= c_start;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_idle;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx       = r_tx;
    assign bus.busy     = (r_state != c_idle);
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_oport_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_oport_uart_tx
// Brief    : Directed bench for oport_uart_tx with CLKS_PER_BIT=4, depth 4.
// Revision : 1.0
// ============================================================================
module tb_oport_uart_tx;
    localparam int CLKS_PER_BIT = 4;
    localparam int FIFO_DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    oport_uart_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) u_if ();

    oport_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks cycles first..last of a frame, starting at the current cycle.
    task automatic check_frame(input logic [7:0] b, input int first, input int last);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = first; i <= last; i++) begin
            chk($sformatf("frame%02h_c%0d", b, i), 32'(u_if.tx), 32'(f[i / CLKS_PER_BIT]));
            tick();
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx"},       32'(u_if.tx),       32'd1);
        chk({tag, "_busy"},     32'(u_if.busy),     32'd0);
        chk({tag, "_empty"},    32'(u_if.empty),    32'd1);
        chk({tag, "_full"},     32'(u_if.full),     32'd0);
        chk({tag, "_count"},    32'(u_if.count),    32'd0);
        chk({tag, "_overflow"}, 32'(u_if.overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.data  = 8'h00;
        u_if.wr_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk_reset_values("post_reset");
        tick();

        // Single byte, exact two-edge latency
        u_if.data = 8'hA5; u_if.wr_en = 1'b1;
        tick();
        u_if.wr_en = 1'b0; u_if.data = 8'h00;
        chk("a5_empty_e0", 32'(u_if.empty), 32'd0);
        chk("a5_count_e0", 32'(u_if.count), 32'd1);
        chk("a5_tx_e0",    32'(u_if.tx),    32'd1);
        tick();
        chk("a5_busy_e1",  32'(u_if.busy),  32'd1);
        chk("a5_empty_e1", 32'(u_if.empty), 32'd1);
        check_frame(8'hA5, 0, 39);
        chk("a5_busy_end",  32'(u_if.busy),  32'd0);
        chk("a5_empty_end", 32'(u_if.empty), 32'd1);
        chk("a5_tx_end",    32'(u_if.tx),    32'd1);
        tick();

        // Three back-to-back writes, contiguous frames
        u_if.data = 8'h01; u_if.wr_en = 1'b1;
        tick();
        chk("b2b_count_e0", 32'(u_if.count), 32'd1);
        u_if.data = 8'h80;
        tick();
        chk("b2b_count_e1", 32'(u_if.count), 32'd1);
        chk("b2b_tx_e1",    32'(u_if.tx),    32'd0);
        u_if.data = 8'hFF;
        tick();
        u_if.wr_en = 1'b0;
        chk("b2b_count_e2", 32'(u_if.count), 32'd2);
        check_frame(8'h01, 1, 39);
        check_frame(8'h80, 0, 39);
        check_frame(8'hFF, 0, 39);
        chk("b2b_busy_end",  32'(u_if.busy),  32'd0);
        chk("b2b_empty_end", 32'(u_if.empty), 32'd1);
        tick();

        // Overflow: one byte in flight, six writes into a 4-deep FIFO
        u_if.data = 8'h11; u_if.wr_en = 1'b1;
        tick();
        u_if.wr_en = 1'b0;
        tick();
        chk("ovf_tx_e1", 32'(u_if.tx), 32'd0);
        for (int k = 0; k < 6; k++) begin
            u_if.data = 8'(8'h21 + k); u_if.wr_en = 1'b1;
            tick();
            chk($sformatf("ovf_count_w%0d", k), 32'(u_if.count),    32'((k < 4) ? k + 1 : 4));
            chk($sformatf("ovf_full_w%0d", k),  32'(u_if.full),     32'(k >= 3));
            chk($sformatf("ovf_flag_w%0d", k),  32'(u_if.overflow), 32'(k >= 4));
        end
        u_if.wr_en = 1'b0;
        check_frame(8'h11, 6, 39);
        check_frame(8'h21, 0, 39);
        check_frame(8'h22, 0, 39);
        check_frame(8'h23, 0, 39);
        check_frame(8'h24, 0, 39);
        chk("ovf_busy_end",  32'(u_if.busy),     32'd0);
        chk("ovf_empty_end", 32'(u_if.empty),    32'd1);
        chk("ovf_sticky",    32'(u_if.overflow), 32'd1);

        // Asynchronous reset takes effect without a clock edge
        rst = 1'b1;
        #2;
        chk_reset_values("async_idle");
        tick();
        rst = 1'b0;
        tick();

        // Write while full on the exact edge STOP completes and pops
        u_if.data = 8'h31; u_if.wr_en = 1'b1;
        tick();
        u_if.wr_en = 1'b0;
        tick();
        chk("fp_tx_e1", 32'(u_if.tx), 32'd0);
        for (int k = 0; k < 4; k++) begin
            u_if.data = 8'(8'h32 + k); u_if.wr_en = 1'b1;
            tick();
        end
        u_if.wr_en = 1'b0;
        chk("fp_count_full", 32'(u_if.count),    32'd4);
        chk("fp_full",       32'(u_if.full),     32'd1);
        chk("fp_ovf_before", 32'(u_if.overflow), 32'd0);
        check_frame(8'h31, 4, 38);
        chk("fp_tx_lastcyc", 32'(u_if.tx),    32'd1);
        chk("fp_count_last", 32'(u_if.count), 32'd4);
        u_if.data = 8'h99; u_if.wr_en = 1'b1;
        tick();
        u_if.wr_en = 1'b0;
        chk("fp_ovf_after",   32'(u_if.overflow), 32'd1);
        chk("fp_count_after", 32'(u_if.count),    32'd3);
        chk("fp_full_after",  32'(u_if.full),     32'd0);
        check_frame(8'h32, 0, 39);
        check_frame(8'h33, 0, 39);
        check_frame(8'h34, 0, 39);
        check_frame(8'h35, 0, 39);
        chk("fp_busy_end",  32'(u_if.busy),  32'd0);
        chk("fp_empty_end", 32'(u_if.empty), 32'd1);

        // Reset during DATA bit 3 of 0x3C
        u_if.data = 8'h3C; u_if.wr_en = 1'b1;
        tick();
        u_if.wr_en = 1'b0;
        tick();
        check_frame(8'h3C, 0, 17);
        rst = 1'b1;
        #2;
        chk_reset_values("midframe");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            u_if.data = 8'($urandom);
            chk($sformatf("quiet_tx_c%0d", i), 32'(u_if.tx), 32'd1);
            tick();
        end
        chk("quiet_busy",  32'(u_if.busy),  32'd0);
        chk("quiet_empty", 32'(u_if.empty), 32'd1);

        u_if.data = 8'h55; u_if.wr_en = 1'b1;
        tick();
        u_if.wr_en = 1'b0; u_if.data = 8'hAA;
        chk("x55_tx_e0", 32'(u_if.tx), 32'd1);
        tick();
        check_frame(8'h55, 0, 39);
        chk("x55_busy_end",  32'(u_if.busy),  32'd0);
        chk("x55_empty_end", 32'(u_if.empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
